// File: rtl/ram_arbiter_2port.sv
// ram_arbiter_2port
//   Round-robin arbiter/sequencer that lets two masters share the single
//   write/address/data port of a synchronous RAM. One transaction is in
//   flight at a time: IDLE (arbitrate + accept) -> ACCESS (drive RAM) ->
//   optional WAIT (cover RAM read latency) -> IDLE.
//
// Parameters
//   ADDR_W    RAM address width
//   DATA_W    RAM data width
//   READ_LAT  cycles from ram_addr driven to ram_dout valid (0..7)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake, N = 0,1
//   reqN_wr/addr/wdata         request fields, stable while valid
//   rspN_valid                 one-cycle pulse when read data is returned
//   rspN_rdata                 read data, held until the next response
//   ram_wr/ram_addr/ram_din    RAM port (this block is its only driver)
//   ram_dout                   RAM read data
//   busy                       high whenever a transaction is in progress
module ram_arbiter_2port #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    localparam bit       LAT0   = (READ_LAT == 0);
    // WAIT counter preload; counts down to zero, capture on zero.
    localparam logic [2:0] LAT_M1 = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;

    state_t              r_state;
    logic                r_ptr;      // last granted id
    logic                r_id;       // id of the transaction in flight
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_cnt;
    logic                r_ram_wr;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic [DATA_W-1:0]   r_rsp0_rdata;
    logic [DATA_W-1:0]   r_rsp1_rdata;

    logic                w_idle;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_hs;
    logic                w_capture;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // Ready is gated by rst_n so nothing is accepted while reset is held,
    // even though the FSM already sits in IDLE.
    assign w_idle   = (r_state == IDLE) & rst_n;
    // req0 wins unless req1 is also valid and req0 was granted last.
    assign w_grant0 = req0_valid & (~req1_valid | r_ptr);
    assign w_grant1 = req1_valid & ~w_grant0;
    assign w_hs     = w_idle & (w_grant0 | w_grant1);

    assign req0_ready = w_idle & w_grant0;
    assign req1_ready = w_idle & w_grant1;

    assign w_sel_wr    = w_grant1 ? req1_wr    : req0_wr;
    assign w_sel_addr  = w_grant1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant1 ? req1_wdata : req0_wdata;

    // Read data is sampled at the end of ACCESS when there is no latency,
    // otherwise at the end of the last WAIT cycle.
    assign w_capture = ((r_state == ACCESS) & ~r_wr & LAT0) |
                       ((r_state == WAIT) & (r_cnt == 3'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= 1'b1;
            r_id         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= 3'd0;
            r_ram_wr     <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;

            if (w_capture) begin
                if (r_id) begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_rdata <= ram_dout;
                end else begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_rdata <= ram_dout;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_id     <= w_grant1;
                        r_ptr    <= w_grant1;
                        r_wr     <= w_sel_wr;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        // ram_wr is registered so it is high exactly in ACCESS
                        r_ram_wr <= w_sel_wr;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_ram_wr <= 1'b0;
                    if (r_wr || LAT0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'd0) r_state <= IDLE;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_wr     = r_ram_wr;
    assign ram_addr   = r_addr;
    assign ram_din    = r_wdata;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;
    assign busy       = (r_state != IDLE);

endmodule
